pflink_rx_framer: RTL and testbench
===================================

# pflink_rx_framer

Receive-side frame extractor for the PF optical link. Sits directly downstream of the link receiver and consumes its aligned 32-bit word stream (`rx_d`/`rx_k`/`rx_v`) in the `clk_link` domain. It finds start-of-frame commas, strips fill words, emits payload words with framing strobes, verifies a trailing checksum, and keeps good/bad frame counters for slow-control readout.

## Interface
- `MAX_LEN`, 255: largest accepted payload length in words; must be 1..65535.
- `CNT_W`, 16: width of the frame counters.

- `clk_link` in 1: link user clock; all logic is on this clock.
- `reset` in 1: asynchronous, active-high reset.
- `rx_d` in 32: received word, byte 0 = `[7:0]`.
- `rx_k` in 4: per-byte K flags.
- `rx_v` in 1: word valid; low means the link is not OK.
- `counter_reset` in 1: synchronous clear of `count_ok` and `count_bad`.
- `out_d` out 32: payload word.
- `out_v` out 1: `out_d` is valid.
- `out_sof` out 1: first payload word of a frame; qualified by `out_v`.
- `out_eof` out 1: last payload word of a frame by length; qualified by `out_v`.
- `out_type` out 8: frame type from the header; held from SOF until the next SOF.
- `frame_done` out 1: one-cycle strobe when a frame completes or aborts.
- `frame_bad` out 1: qualifies `frame_done`; 1 = checksum error or abort.
- `err_code` out 2: qualifies `frame_done`. 0 = ok, 1 = checksum mismatch, 2 = unexpected K or `rx_v` loss, 3 = new SOF before the frame completed.
- `count_ok` out `CNT_W`: saturating count of good frames.
- `count_bad` out `CNT_W`: saturating count of bad frames and rejected headers.

## Operation
Word classes:
- **SOF**: `rx_v`=1, `rx_k`=4'b0001, `rx_d[7:0]`=8'hBC. Then `rx_d[15:8]` is the type and `rx_d[31:16]` is the length N.
- **FILL**: `rx_k`=4'hF. This covers idle and pad words.
- **DATA**: `rx_k`=4'h0.
- **BADK**: any other `rx_k` pattern.

State machine: HUNT, PAYLOAD, CHECK.
- **HUNT**
  - Ignore everything except SOF.
  - On SOF with 1 ≤ N ≤ `MAX_LEN`: latch type, set remaining = N, clear the sum, go to PAYLOAD.
  - On SOF with N = 0 or N > `MAX_LEN`: stay in HUNT, increment `count_bad`, no `frame_done`.
- **PAYLOAD**
  - DATA: output the word, add it to the sum, decrement remaining. When remaining reaches 0, go to CHECK.
  - FILL: skipped. No output, no count.
  - SOF: abort with code 3, then treat it as a new header in the same cycle (the same length rules as HUNT apply).
  - BADK or `rx_v`=0: abort with code 2, go to HUNT.
- **CHECK**
  - FILL: skipped.
  - DATA: compare it against the sum. Match gives done/ok; mismatch gives done/bad, code 1. Either way go to HUNT.
  - SOF and BADK/`rx_v`=0: same handling as in PAYLOAD.

Rules:
- Checksum: 32-bit wrap-around sum (mod 2^32) of the N payload words.
- `out_sof` is on the first DATA word after SOF. `out_eof` is on the Nth DATA word. When N=1, both are set on the same word.
- An abort produces no `out_eof`. Downstream uses `frame_done` with `frame_bad`=1 to discard the partial frame.
- Counters saturate at all-ones.
- `frame_done` with `frame_bad`=0 increments `count_ok`. `frame_done` with `frame_bad`=1 increments `count_bad`.
- When `counter_reset` and an increment occur in the same cycle, the clear wins.

## Timing
- Every output is registered.
- Reset values: all outputs 0, state HUNT, internal sum and remaining 0.
- `out_*` follows the accepted input word by exactly 1 cycle.
- `frame_done`/`frame_bad`/`err_code` appear 1 cycle after the check word or after the aborting word.
  - They are a single-cycle pulse.
  - `err_code` and `frame_bad` are 0 whenever `frame_done`=0.
- A new SOF is accepted on the cycle right after a check word; there are no dead cycles.
- SOF-abort (code 3) gives `frame_done` and the new frame's first `out_sof` on separate cycles, because the first payload word follows the SOF.
- Throughput: one payload word per cycle, with no backpressure. Downstream must accept every `out_v`.
- Asserting `reset` mid-frame clears everything immediately. No `frame_done` is issued for the lost frame.

## Test plan
- SOF type=8'h5A, N=3; DATA 1, 2, 3; check 6.
  - Required: `out_v` for 3 cycles, `out_sof` on 1, `out_eof` on 3, `out_type`=8'h5A.
  - Required: then `frame_done`=1, `frame_bad`=0, and `count_ok`=1.
- Same frame with the check word 7.
  - Required: `frame_done`, `frame_bad`=1, `err_code`=1, `count_bad`=1, and the payload is still output.
- N=2 with FILL words inserted between the DATA words and before the check word.
  - Required: identical output to the frame without FILL, `out_v` gaps only, checksum ok.
- Loss and BADK mid-frame:
  - `rx_v`=0 after 1 of 4 words → `err_code`=2, return to HUNT.
  - `rx_k`=4'b0100 mid-frame → `err_code`=2.
- SOF with N=0, and SOF with N=`MAX_LEN`+1.
  - Required: no `out_v`, no `frame_done`, `count_bad` incremented twice.
- SOF mid-payload, then a full valid frame.
  - Required: abort with code 3, then a good frame, so `count_ok`=1 and `count_bad`=1.
- Counter saturation with `CNT_W`=4: after 20 good frames `count_ok`=15; `counter_reset` then returns it to 0.

Source files
------------

// File: rtl/pflink_rx_framer.sv
// rtl/pflink_rx_framer.sv - PF link receive frame extractor with checksum verification and frame counters
module pflink_rx_framer #(
    parameter int MAX_LEN = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk_link,
    input  logic             reset,
    input  logic [31:0]      rx_d,
    input  logic [3:0]       rx_k,
    input  logic             rx_v,
    input  logic             counter_reset,
    output logic [31:0]      out_d,
    output logic             out_v,
    output logic             out_sof,
    output logic             out_eof,
    output logic [7:0]       out_type,
    output logic             frame_done,
    output logic             frame_bad,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] count_ok,
    output logic [CNT_W-1:0] count_bad
);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    state_t      state, state_n;
    logic [15:0] rem, rem_n;
    logic [31:0] sum, sum_n;
    logic        first, first_n;

    logic [31:0] out_d_n;
    logic        out_v_n, out_sof_n, out_eof_n;
    logic [7:0]  out_type_n;
    logic        done_n, bad_n;
    logic [1:0]  err_n;
    logic        ok_inc, bad_abort, bad_hdr, take_hdr;
    logic [1:0]  bad_inc;

    logic        is_sof, is_fill, is_data, hdr_ok;
    logic [15:0] hdr_len;

    assign is_sof  = rx_v && (rx_k == 4'b0001) && (rx_d[7:0] == 8'hBC);
    assign is_fill = rx_v && (rx_k == 4'hF);
    assign is_data = rx_v && (rx_k == 4'h0);
    assign hdr_len = rx_d[31:16];
    assign hdr_ok  = (hdr_len != 16'd0) && (hdr_len <= MAX_LEN_W);
    assign bad_inc = {1'b0, bad_abort} + {1'b0, bad_hdr};

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] inc);
        logic [CNT_W:0] s;
        s = {1'b0, c} + {{(CNT_W-1){1'b0}}, inc};
        sat_add = s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    always_comb begin
        state_n    = state;
        rem_n      = rem;
        sum_n      = sum;
        first_n    = first;
        out_d_n    = out_d;
        out_v_n    = 1'b0;
        out_sof_n  = 1'b0;
        out_eof_n  = 1'b0;
        out_type_n = out_type;
        done_n     = 1'b0;
        bad_n      = 1'b0;
        err_n      = 2'd0;
        ok_inc     = 1'b0;
        bad_abort  = 1'b0;
        bad_hdr    = 1'b0;
        take_hdr   = 1'b0;

        case (state)
            HUNT: begin
                take_hdr = is_sof;
            end
            PAYLOAD, CHECK: begin
                if (is_sof) begin
                    // Abort the open frame, then reuse this word as the next header
                    done_n    = 1'b1;
                    bad_n     = 1'b1;
                    err_n     = 2'd3;
                    bad_abort = 1'b1;
                    take_hdr  = 1'b1;
                end else if (!is_fill && !is_data) begin
                    done_n    = 1'b1;
                    bad_n     = 1'b1;
                    err_n     = 2'd2;
                    bad_abort = 1'b1;
                    state_n   = HUNT;
                end else if (is_data && state == PAYLOAD) begin
                    out_d_n   = rx_d;
                    out_v_n   = 1'b1;
                    out_sof_n = first;
                    out_eof_n = (rem == 16'd1);
                    first_n   = 1'b0;
                    sum_n     = sum + rx_d;
                    rem_n     = rem - 16'd1;
                    if (rem == 16'd1) state_n = CHECK;
                end else if (is_data) begin
                    done_n    = 1'b1;
                    state_n   = HUNT;
                    if (rx_d == sum) begin
                        ok_inc = 1'b1;
                    end else begin
                        bad_n     = 1'b1;
                        err_n     = 2'd1;
                        bad_abort = 1'b1;
                    end
                end
            end
            default: state_n = HUNT;
        endcase

        if (take_hdr) begin
            if (hdr_ok) begin
                out_type_n = rx_d[15:8];
                rem_n      = hdr_len;
                sum_n      = 32'd0;
                first_n    = 1'b1;
                state_n    = PAYLOAD;
            end else begin
                bad_hdr = 1'b1;
                state_n = HUNT;
            end
        end
    end

    always_ff @(posedge clk_link or posedge reset) begin
        if (reset) begin
            state      <= HUNT;
            rem        <= 16'd0;
            sum        <= 32'd0;
            first      <= 1'b0;
            out_d      <= 32'd0;
            out_v      <= 1'b0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            out_type   <= 8'd0;
            frame_done <= 1'b0;
            frame_bad  <= 1'b0;
            err_code   <= 2'd0;
            count_ok   <= '0;
            count_bad  <= '0;
        end else begin
            state      <= state_n;
            rem        <= rem_n;
            sum        <= sum_n;
            first      <= first_n;
            out_d      <= out_d_n;
            out_v      <= out_v_n;
            out_sof    <= out_sof_n;
            out_eof    <= out_eof_n;
            out_type   <= out_type_n;
            frame_done <= done_n;
            frame_bad  <= bad_n;
            err_code   <= err_n;
            if (counter_reset) begin
                count_ok  <= '0;
                count_bad <= '0;
            end else begin
                count_ok  <= sat_add(count_ok, {1'b0, ok_inc});
                count_bad <= sat_add(count_bad, bad_inc);
            end
        end
    end

endmodule

// File: tb/tb_pflink_rx_framer.sv
// tb/tb_pflink_rx_framer.sv - scoreboard bench for pflink_rx_framer
module tb_pflink_rx_framer;

    localparam int CW  = 4;
    localparam int SAT = 15;

    logic          clk_link = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   rx_d = 32'd0;
    logic [3:0]    rx_k = 4'hF;
    logic          rx_v = 1'b1;
    logic          counter_reset = 1'b0;
    logic [31:0]   out_d;
    logic          out_v, out_sof, out_eof;
    logic [7:0]    out_type;
    logic          frame_done, frame_bad;
    logic [1:0]    err_code;
    logic [CW-1:0] count_ok, count_bad;

    pflink_rx_framer #(.MAX_LEN(255), .CNT_W(CW)) dut (
        .clk_link(clk_link), .reset(reset), .rx_d(rx_d), .rx_k(rx_k), .rx_v(rx_v),
        .counter_reset(counter_reset), .out_d(out_d), .out_v(out_v), .out_sof(out_sof),
        .out_eof(out_eof), .out_type(out_type), .frame_done(frame_done), .frame_bad(frame_bad),
        .err_code(err_code), .count_ok(count_ok), .count_bad(count_bad)
    );

    always #5 clk_link = ~clk_link;

    int pass_cnt = 0;
    int total_cnt = 0;
    int exp_ok = 0;
    int exp_bad = 0;
    logic [7:0] last_type = 8'd0;

    logic [41:0] exp_q[$];
    logic [2:0]  done_q[$];
    logic [41:0] e;
    logic [2:0]  de;

    always @(negedge clk_link) begin
        if (!reset) begin
            if (out_v) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL out_word: unexpected out_v, out_d=%h", out_d);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_d, out_sof, out_eof, out_type} !== e)
                        $display("FAIL out_word: got d=%h sof=%b eof=%b type=%h, want d=%h sof=%b eof=%b type=%h",
                                 out_d, out_sof, out_eof, out_type, e[41:10], e[9], e[8], e[7:0]);
                    else pass_cnt++;
                end
            end
            total_cnt++;
            if (frame_done) begin
                if (done_q.size() == 0) begin
                    $display("FAIL frame_done: unexpected, bad=%b err=%0d", frame_bad, err_code);
                end else begin
                    de = done_q.pop_front();
                    if ({frame_bad, err_code} !== de)
                        $display("FAIL frame_done: got bad=%b err=%0d, want bad=%b err=%0d",
                                 frame_bad, err_code, de[2], de[1:0]);
                    else pass_cnt++;
                end
            end else if (frame_bad !== 1'b0 || err_code !== 2'd0) begin
                $display("FAIL idle_qual: got bad=%b err=%0d, want 0 0", frame_bad, err_code);
            end else pass_cnt++;
        end
    end

    task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic v);
        rx_d = d; rx_k = k; rx_v = v;
        @(posedge clk_link);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(32'hBCBCBCBC, 4'hF, 1'b1);
    endtask

    task automatic send_sof(input logic [7:0] t, input logic [15:0] len);
        drive({len, t, 8'hBC}, 4'b0001, 1'b1);
    endtask

    task automatic bump_bad();
        exp_bad = (exp_bad < SAT) ? exp_bad + 1 : SAT;
    endtask

    task automatic clear_counters();
        counter_reset = 1'b1;
        idle(1);
        counter_reset = 1'b0;
        exp_ok = 0; exp_bad = 0;
    endtask

    // base != 0 gives payload base, base+1, ...; otherwise random payload
    task automatic send_frame(input logic [7:0] t, input int n, input int base,
                              input bit corrupt, input bit fills);
        logic [31:0] w, s;
        s = 32'd0;
        send_sof(t, n[15:0]);
        last_type = t;
        for (int i = 0; i < n; i++) begin
            w = (base != 0) ? 32'(base + i) : $urandom;
            s = s + w;
            exp_q.push_back({w, i == 0, i == n - 1, t});
            drive(w, 4'h0, 1'b1);
            if (fills) idle(2);
        end
        drive(corrupt ? s + 32'd1 : s, 4'h0, 1'b1);
        if (corrupt) begin
            done_q.push_back({1'b1, 2'd1});
            bump_bad();
        end else begin
            done_q.push_back(3'b000);
            exp_ok = (exp_ok < SAT) ? exp_ok + 1 : SAT;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk_link);
        #1;
        total_cnt++;
        if ({out_d, out_v, out_sof, out_eof, out_type, frame_done, frame_bad, err_code, count_ok, count_bad} !== '0)
            $display("FAIL reset_outputs: got d=%h v=%b type=%h done=%b ok=%0d bad=%0d, want all 0",
                     out_d, out_v, out_type, frame_done, count_ok, count_bad);
        else pass_cnt++;
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_good_frame();
        send_frame(8'h5A, 3, 1, 1'b0, 1'b0);
        idle(3);
        total_cnt++;
        if (count_ok !== CW'(exp_ok) || exp_ok != 1) $display("FAIL good_count_ok: got %0d want 1", count_ok);
        else pass_cnt++;
        total_cnt++;
        if (out_type !== 8'h5A) $display("FAIL good_type_hold: got %h want 5a", out_type);
        else pass_cnt++;
    endtask

    task automatic test_bad_checksum();
        send_frame(8'h5A, 3, 1, 1'b1, 1'b0);
        idle(3);
        total_cnt++;
        if (count_bad !== CW'(exp_bad)) $display("FAIL cksum_count_bad: got %0d want %0d", count_bad, exp_bad);
        else pass_cnt++;
    endtask

    task automatic test_fill();
        send_frame(8'h3C, 2, 0, 1'b0, 1'b1);
        idle(3);
        total_cnt++;
        if (count_ok !== CW'(exp_ok)) $display("FAIL fill_count_ok: got %0d want %0d", count_ok, exp_ok);
        else pass_cnt++;
    endtask

    task automatic test_abort_loss();
        logic [31:0] w;
        send_sof(8'h11, 16'd4);
        w = $urandom;
        exp_q.push_back({w, 1'b1, 1'b0, 8'h11});
        drive(w, 4'h0, 1'b1);
        drive(32'h0, 4'h0, 1'b0);
        done_q.push_back({1'b1, 2'd2});
        bump_bad();
        send_sof(8'h12, 16'd3);
        for (int i = 0; i < 2; i++) begin
            w = $urandom;
            exp_q.push_back({w, i == 0, 1'b0, 8'h12});
            drive(w, 4'h0, 1'b1);
        end
        drive(32'h0, 4'b0100, 1'b1);
        done_q.push_back({1'b1, 2'd2});
        bump_bad();
        last_type = 8'h12;
        drive(32'h0000_0005, 4'h0, 1'b1);
        idle(3);
        total_cnt++;
        if (count_bad !== CW'(exp_bad) || exp_q.size() + done_q.size() != 0)
            $display("FAIL abort_k2: got bad=%0d pending=%0d, want bad=%0d pending=0",
                     count_bad, exp_q.size() + done_q.size(), exp_bad);
        else pass_cnt++;
    endtask

    task automatic test_bad_header();
        send_sof(8'h66, 16'd0);
        bump_bad();
        send_sof(8'h67, 16'd256);
        bump_bad();
        drive(32'h1234, 4'h0, 1'b1);
        idle(3);
        total_cnt++;
        if (count_bad !== CW'(exp_bad)) $display("FAIL hdr_count_bad: got %0d want %0d", count_bad, exp_bad);
        else pass_cnt++;
        total_cnt++;
        if (out_type !== last_type) $display("FAIL hdr_type_kept: got %h want %h", out_type, last_type);
        else pass_cnt++;
    endtask

    task automatic test_sof_abort();
        logic [31:0] w;
        clear_counters();
        send_sof(8'h21, 16'd4);
        for (int i = 0; i < 2; i++) begin
            w = $urandom;
            exp_q.push_back({w, i == 0, 1'b0, 8'h21});
            drive(w, 4'h0, 1'b1);
        end
        done_q.push_back({1'b1, 2'd3});
        bump_bad();
        send_frame(8'h22, 2, 0, 1'b0, 1'b0);
        idle(3);
        total_cnt++;
        if (count_ok !== 1 || count_bad !== 1) $display("FAIL sofabort_counts: got ok=%0d bad=%0d want 1 1", count_ok, count_bad);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        send_frame(8'h44, 1, 0, 1'b0, 1'b0);
        send_frame(8'h45, 3, 0, 1'b0, 1'b0);
        send_frame(8'h46, 2, 0, 1'b1, 1'b0);
        idle(3);
        total_cnt++;
        if (count_ok !== CW'(exp_ok) || count_bad !== CW'(exp_bad))
            $display("FAIL b2b_counts: got ok=%0d bad=%0d want %0d %0d", count_ok, count_bad, exp_ok, exp_bad);
        else pass_cnt++;
    endtask

    task automatic test_reset_midframe();
        send_sof(8'h33, 16'd4);
        drive(32'hDEAD0001, 4'h0, 1'b1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        exp_ok = 0; exp_bad = 0;
        total_cnt++;
        if ({out_type, count_ok, count_bad} !== '0) $display("FAIL midreset: got type=%h ok=%0d bad=%0d want 0", out_type, count_ok, count_bad);
        else pass_cnt++;
        send_frame(8'h34, 2, 0, 1'b0, 1'b0);
        idle(3);
        total_cnt++;
        if (count_ok !== 1 || count_bad !== 0) $display("FAIL midreset_after: got ok=%0d bad=%0d want 1 0", count_ok, count_bad);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        logic [31:0] w;
        clear_counters();
        for (int i = 0; i < 20; i++) send_frame(8'h55, 1, 0, 1'b0, 1'b0);
        idle(3);
        total_cnt++;
        if (count_ok !== 4'd15 || exp_ok != 15) $display("FAIL sat_count_ok: got %0d want 15", count_ok);
        else pass_cnt++;
        // clear coincides with the increment from this check word
        send_sof(8'h56, 16'd1);
        w = $urandom;
        exp_q.push_back({w, 1'b1, 1'b1, 8'h56});
        drive(w, 4'h0, 1'b1);
        done_q.push_back(3'b000);
        counter_reset = 1'b1;
        drive(w, 4'h0, 1'b1);
        counter_reset = 1'b0;
        exp_ok = 0; exp_bad = 0;
        idle(3);
        total_cnt++;
        if (count_ok !== 0 || count_bad !== 0) $display("FAIL clear_wins: got ok=%0d bad=%0d want 0 0", count_ok, count_bad);
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() + done_q.size() != 0) $display("FAIL pending_end: got %0d entries want 0", exp_q.size() + done_q.size());
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_fill();
        test_abort_loss();
        test_bad_header();
        test_sof_abort();
        test_back_to_back();
        test_reset_midframe();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
